instr_fetch_unit: RTL and testbench

//  Instruction-fetch stage: consumes the PC register output, issues in-order

---
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/instr_fetch_unit.sv | 87 ++++++++
 tb/tb_instr_fetch_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read channel plus the IF/ID handshake.
// master = fetch unit side, slave = memory / decode side.
interface instr_fetch_unit_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;

    logic            id_valid;
    logic            id_ready;
    logic [ILEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_gnt, imem_rvalid, imem_rdata, id_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: credit-limited in-order imem reads, a PC tag queue and a
// small {pc, instr} buffer feeding decode; flush turns in-flight reads into drops.
module instr_fetch_unit #(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_advance,
    input  logic            flush,
    instr_fetch_unit_if.master fu
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ILEN-1:0] NOP = ILEN'(32'h00000013);

    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [CW:0]   used;

    logic [XLEN-1:0] tag_mem   [DEPTH];
    logic [XLEN-1:0] buf_pc    [DEPTH];
    logic [ILEN-1:0] buf_instr [DEPTH];
    logic [AW-1:0]   tag_wr, tag_rd;
    logic [AW-1:0]   buf_wr, buf_rd;

    logic accept;
    logic rsp_drop;
    logic rsp_take;
    logic pop;

    always_comb begin
        used        = {1'b0, outstanding} + {1'b0, drop_cnt} + {1'b0, count};
        fu.imem_req = reset & ~flush & (used < (CW+1)'(DEPTH));
        fu.imem_addr = pc_in;
        accept      = fu.imem_req & fu.imem_gnt;
        pc_advance  = accept;
        rsp_drop    = fu.imem_rvalid & (drop_cnt != '0);
        rsp_take    = fu.imem_rvalid & (drop_cnt == '0) & (outstanding != '0);
        fu.id_valid = (count != '0);
        fu.id_pc    = fu.id_valid ? buf_pc[buf_rd]    : '0;
        fu.id_instr = fu.id_valid ? buf_instr[buf_rd] : NOP;
        pop         = fu.id_valid & fu.id_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            buf_wr      <= '0;
            buf_rd      <= '0;
        end else if (flush) begin
            // Every read still owed by memory becomes a drop; a response arriving
            // this very cycle has already settled one of them.
            drop_cnt    <= drop_cnt + outstanding - CW'(rsp_drop | rsp_take);
            outstanding <= '0;
            count       <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            buf_wr      <= '0;
            buf_rd      <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(rsp_take);
            drop_cnt    <= drop_cnt - CW'(rsp_drop);
            count       <= count + CW'(rsp_take) - CW'(pop);
            if (accept)   tag_wr <= tag_wr + 1'b1;
            if (rsp_take) tag_rd <= tag_rd + 1'b1;
            if (rsp_take) buf_wr <= buf_wr + 1'b1;
            if (pop)      buf_rd <= buf_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            tag_mem[tag_wr] <= pc_in;
        if (rsp_take) begin
            buf_pc[buf_wr]    <= tag_mem[tag_rd];
            buf_instr[buf_wr] <= fu.imem_rdata;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: a memory/PC environment model
// issues stimulus and predicts the decode stream; a monitor compares every cycle.
module tb_instr_fetch_unit;
    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int DEPTH = 2;
    localparam logic [ILEN-1:0] NOP = 32'h00000013;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            flush = 1'b0;
    logic            pc_advance;
    logic [XLEN-1:0] pc_in = '0;

    instr_fetch_unit_if #(.XLEN(XLEN), .ILEN(ILEN)) fu ();

    instr_fetch_unit #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_advance (pc_advance),
        .flush      (flush),
        .fu         (fu)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } item_t;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] data;
        bit              live;
        int unsigned     due;
    } pend_t;

    item_t exp_q[$];   // words the decode side must still receive, in order
    pend_t mem_q[$];   // reads granted by memory and not yet answered

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    bit mon_en = 1'b0;
    logic [XLEN-1:0] pc_model = '0;

    int unsigned p_gnt = 100, p_rdy = 100, p_flush = 0, p_unsol = 0, max_lat = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock of environment: drive at negedge, update the model after the monitor.
    task automatic cycle();
        pend_t p;
        item_t it;
        bit    acc;
        @(negedge clk);
        cyc++;
        flush       = ($urandom_range(0, 99) < p_flush);
        fu.imem_gnt = ($urandom_range(0, 99) < p_gnt);
        fu.id_ready = ($urandom_range(0, 99) < p_rdy);
        pc_in       = pc_model;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc && $urandom_range(0, 99) < 80) begin
            fu.imem_rvalid = 1'b1;
            fu.imem_rdata  = mem_q[0].data;
        end else if (mem_q.size() == 0 && $urandom_range(0, 99) < p_unsol) begin
            fu.imem_rvalid = 1'b1;
            fu.imem_rdata  = $urandom;
        end else begin
            fu.imem_rvalid = 1'b0;
            fu.imem_rdata  = $urandom;
        end
        #2;
        acc = fu.imem_req && fu.imem_gnt;
        if (fu.imem_rvalid && mem_q.size() != 0) begin
            p = mem_q.pop_front();
            if (p.live && !flush) begin
                it.pc    = p.pc;
                it.instr = p.data;
                exp_q.push_back(it);
            end
        end
        if (flush) begin
            foreach (mem_q[i]) mem_q[i].live = 1'b0;
            exp_q.delete();
            pc_model = {$urandom, $urandom} & ~64'h3;
        end
        if (acc) begin
            p.pc   = pc_in;
            p.data = $urandom;
            p.live = 1'b1;
            p.due  = cyc + 1 + $urandom_range(0, max_lat);
            mem_q.push_back(p);
            pc_model = pc_in + 64'd4;
        end
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle();
    endtask

    // Monitor: credit rule, handshake and head-of-queue data every cycle.
    initial begin
        bit exp_req;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                exp_req = !flush && (mem_q.size() + exp_q.size() < DEPTH);
                chk("imem_req", 64'(fu.imem_req), 64'(exp_req));
                chk("pc_advance", 64'(pc_advance), 64'(exp_req && fu.imem_gnt));
                if (exp_req) chk("imem_addr", fu.imem_addr, pc_in);
                chk("id_valid", 64'(fu.id_valid), 64'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    chk("id_pc", fu.id_pc, exp_q[0].pc);
                    chk("id_instr", 64'(fu.id_instr), 64'(exp_q[0].instr));
                    if (fu.id_ready) void'(exp_q.pop_front());
                end else begin
                    chk("id_pc_idle", fu.id_pc, 64'd0);
                    chk("id_instr_idle", 64'(fu.id_instr), 64'(NOP));
                end
            end
        end
    end

    initial begin
        int unsigned n;
        fu.imem_gnt    = 1'b1;
        fu.imem_rvalid = 1'b0;
        fu.imem_rdata  = '0;
        fu.id_ready    = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_imem_req", 64'(fu.imem_req), 64'd0);
        chk("rst_pc_advance", 64'(pc_advance), 64'd0);
        chk("rst_id_valid", 64'(fu.id_valid), 64'd0);
        chk("rst_id_instr", 64'(fu.id_instr), 64'h13);
        chk("rst_id_pc", fu.id_pc, 64'd0);
        fu.imem_gnt = 1'b0;
        reset = 1'b1;
        mon_en = 1'b1;

        // streaming with immediate responses
        run(30);
        // decode backpressure, then release
        p_rdy = 0;   run(12);
        p_rdy = 100; run(12);
        // directed flush with two reads in flight
        max_lat = 3; p_gnt = 100;
        run(3);
        p_flush = 100; run(1);
        p_flush = 0;   run(15);
        // grant stall
        p_gnt = 0;   run(3);
        p_gnt = 100; run(8);
        // random mix with flushes, stalls and unsolicited responses
        p_gnt = 70; p_rdy = 60; p_flush = 8; p_unsol = 30;
        run(600);
        p_rdy = 30; p_flush = 3; max_lat = 1;
        run(300);

        // drain: no new requests, decode always ready
        p_gnt = 0; p_rdy = 100; p_flush = 0; p_unsol = 0;
        n = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 80) begin
            cycle();
            n++;
        end
        chk("drain_empty", 64'(exp_q.size() + mem_q.size()), 64'd0);
        run(2);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
